jtkunio_gfx_arb: RTL
====================

// Module: jtkunio_gfx_arb
// PURPOSE
// - Shares one 32-bit graphics ROM port among N tile-layer fetchers (char, scroll, objects).
// - Keeps a one-entry address/data cache per client and fetches misses round-robin.
// - Gives each client the same cs/addr/data/ok view a dedicated ROM port would give.
// - Sits between the layer modules and the SDRAM ROM slot in the game top level.
// PARAMETERS
// - N      3      number of client layers (2..4)
// - AW     18     ROM word address width
// - DW     32     ROM data width
// - TMO    255    cycles to wait for rom_ok before abandoning a fetch (8-bit counter)
// PORTS
// - clk        in   1      system clock; the only clock
// - rst_n      in   1      asynchronous active-low reset
// - cl_cs      in   N      per-client request (client i = bit i)
// - cl_addr    in   N*AW   per-client address, client i at [i*AW +: AW]
// - cl_data    out  N*DW   per-client data, client i at [i*DW +: DW]
// - cl_ok      out  N      cl_data[i] is valid for the current cl_addr[i]
// - rom_cs     out  1      shared ROM request
// - rom_addr   out  AW     shared ROM address
// - rom_data   in   DW     shared ROM data
// - rom_ok     in   1      ROM data valid for rom_addr (may stay high from a prior request)
// - busy       out  1      FSM not in IDLE (debug)
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - rom_cs=0, rom_addr=0, busy=0, cl_ok=0, cl_data=0.
//   - All cache valid bits=0 and the round-robin pointer=0.
//   - Any fetch in flight is dropped.
// - Per-client cache: tag[i] (AW), data[i] (DW), vld[i].
// - Hit / cl_ok (combinational):
//   - hit[i] = cl_cs[i] & vld[i] & (tag[i]==cl_addr[i]).
//   - cl_ok[i] = hit[i]; cl_data[i] = data[i] at all times.
// - Miss: miss[i] = cl_cs[i] & ~hit[i].
// - FSM states IDLE, ISSUE, WAIT:
//   - IDLE: if any miss, pick the first miss at or after pointer p (wrapping).
//     Latch sel and addr_l = cl_addr[sel]. Drive rom_addr = addr_l and rom_cs = 1, then go to ISSUE.
//     With no misses, stay in IDLE with rom_cs = 0.
//   - ISSUE: one cycle in which rom_ok is ignored (it may belong to the previous address). Go to WAIT.
//   - WAIT: on rom_ok, write tag[sel] = addr_l, data[sel] = rom_data, vld[sel] = 1.
//     Set p = sel+1 (mod N), rom_cs = 0, then go to IDLE.
// - Latency: a miss with the port free gives cl_ok no earlier than 3 clk after cl_cs/cl_addr settle.
//   That is IDLE→ISSUE, ISSUE→WAIT, then the WAIT cycle that sees rom_ok, plus the SDRAM delay.
// - rom_addr and rom_cs stay stable for the whole of ISSUE and WAIT.
// - A client address change during its own fetch does not abort the fetch:
//   - The fill uses addr_l, so the hit check fails and the client is re-fetched later.
// - cl_cs[sel] dropping mid-fetch: the fetch completes and fills the cache; vld is unaffected.
// - cl_cs low leaves the cache untouched; a later identical address hits with no ROM access.
// - Timeout: an 8-bit counter runs in WAIT.
//   - When it reaches TMO with no rom_ok: rom_cs = 0, go to IDLE, nothing is written, p advances.
// - Fairness: with all N clients missing continuously, grants rotate 0,1,..,N-1,0.
//   No client waits more than N-1 fetches.
// - A new miss never pre-empts a fetch in progress.
// STRUCTURE
// - Shared package jtkunio_gfx_pkg: the FSM state enum (IDLE/ISSUE/WAIT) and the timeout width constant.
// - One sub-module, jtkunio_gfx_rr: an N-way round-robin priority pick.
//   - Inputs: miss vector and pointer p. Outputs: sel and any_miss.
// - Cache arrays, FSM and timeout counter stay in the top module.
// TESTING
// - Reset, then cl_cs=3'b001, addr0=18'h00100, SDRAM model with 4-cycle latency:
//   - rom_cs rises 1 cycle later with rom_addr=18'h00100.
//   - cl_ok[0]=1 with the model's data.
//   - Only one ROM request is issued.
// - Same address held for 100 cycles -> no further rom_cs pulses; cl_ok[0] stays 1.
// - All three clients miss at once (addr 10, 20, 30):
//   - Grants go 0,1,2 in that order.
//   - Each cl_ok rises only after its own fill.
//   - A repeat with new addresses continues 0,1,2.
// - rom_ok held high from the previous fetch:
//   - A new address is not filled during ISSUE.
//   - The cache receives data only from a rom_ok seen in WAIT.
// - Client 1 changes addr 40->44 mid-fetch:
//   - The fill tags 40 and cl_ok[1] stays 0.
//   - A second fetch of 44 follows, and then cl_ok[1]=1.
// - Model never asserts rom_ok:
//   - After 255 WAIT cycles, rom_cs drops and the next client is served.
//   - rst_n pulsed low mid-WAIT clears rom_cs, cl_ok and busy asynchronously.

Source files
------------

// File: rtl/jtkunio_gfx_pkg.sv
// Shared definitions for the kunio graphics ROM arbiter: FSM states,
// timeout counter width and a small wrap-around increment helper.
package jtkunio_gfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Width of the WAIT-state timeout counter.
  localparam int TMO_W = 8;

  // Next round-robin position after v among n clients.
  function automatic int wrap_inc(input int v, input int n);
    int r;
    if (v + 1 >= n) begin
      r = 0;
    end else begin
      r = v + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/jtkunio_gfx_arb_if.sv
// Shared graphics ROM slot bus. The arbiter is the master (drives cs/addr),
// the SDRAM ROM slot is the slave (returns data/ok).
interface jtkunio_gfx_arb_if #(
  parameter int AW = 18,
  parameter int DW = 32
);

  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_ok;

  modport master (
    output rom_cs,
    output rom_addr,
    input  rom_data,
    input  rom_ok
  );

  modport slave (
    input  rom_cs,
    input  rom_addr,
    output rom_data,
    output rom_ok
  );

endinterface

// File: rtl/jtkunio_gfx_rr.sv
// N-way round-robin pick: returns the first set miss bit at or after ptr,
// wrapping around, plus a flag telling whether any bit is set at all.
module jtkunio_gfx_rr
  import jtkunio_gfx_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  miss,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] sel,
  output logic          any_miss
);

  int idx_s;

  // Scan from the farthest offset down to ptr so the nearest miss wins last.
  always_comb begin
    sel      = {PW{1'b0}};
    any_miss = |miss;
    idx_s    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx_s = int'(ptr) + k;
      if (idx_s >= N) begin
        idx_s = idx_s - N;
      end else begin
        idx_s = idx_s;
      end
      if (miss[PW'(idx_s)]) begin
        sel = PW'(idx_s);
      end else begin
        sel = sel;
      end
    end
  end

endmodule

// File: rtl/jtkunio_gfx_arb.sv
// Graphics ROM arbiter: N tile-layer clients share one ROM slot. Each client
// owns a one-entry tag/data cache; misses are fetched one at a time in
// round-robin order, and each client sees a dedicated-port style cs/ok view.
module jtkunio_gfx_arb
  import jtkunio_gfx_pkg::*;
#(
  parameter int N   = 3,
  parameter int AW  = 18,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        cl_cs,
  input  logic [N*AW-1:0]     cl_addr,
  output logic [N*DW-1:0]     cl_data,
  output logic [N-1:0]        cl_ok,
  jtkunio_gfx_arb_if.master   rom,
  output logic                busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     sel_q, sel_d;
  logic [PW-1:0]     pick_s;
  logic [PW-1:0]     ptr_nx_s;
  logic [AW-1:0]     addr_l_q, addr_l_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              rom_cs_q, rom_cs_d;
  logic              any_miss_s;
  logic              fill_s;

  logic [AW-1:0]     tag_q  [N];
  logic [AW-1:0]     tag_d  [N];
  logic [DW-1:0]     data_q [N];
  logic [DW-1:0]     data_d [N];
  logic [N-1:0]      vld_q, vld_d;
  logic [AW-1:0]     addr_s [N];
  logic [N-1:0]      hit_s;
  logic [N-1:0]      miss_s;

  // Unpack client addresses, evaluate per-client hit/miss and expose cached data.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr_s[i]           = cl_addr[i*AW +: AW];
      hit_s[i]            = cl_cs[i] & vld_q[i] & (tag_q[i] == addr_s[i]);
      miss_s[i]           = cl_cs[i] & ~hit_s[i];
      cl_data[i*DW +: DW] = data_q[i];
    end
  end

  assign cl_ok        = hit_s;
  assign rom.rom_cs   = rom_cs_q;
  assign rom.rom_addr = addr_l_q;
  assign busy         = (state_q != ST_IDLE);
  assign ptr_nx_s     = PW'(wrap_inc(int'(sel_q), N));

  jtkunio_gfx_rr #(
    .N  (N),
    .PW (PW)
  ) u_rr (
    .miss     (miss_s),
    .ptr      (ptr_q),
    .sel      (pick_s),
    .any_miss (any_miss_s)
  );

  // Fetch FSM: grant a miss, skip the possibly stale rom_ok cycle, then wait for data or time out.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_l_d = addr_l_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    rom_cs_d = rom_cs_q;
    fill_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {TMO_W{1'b0}};
        if (any_miss_s) begin
          sel_d    = pick_s;
          addr_l_d = addr_s[pick_s];
          rom_cs_d = 1'b1;
          state_d  = ST_ISSUE;
        end else begin
          rom_cs_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        // rom_ok here may still refer to the previous address, so it is ignored.
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rom.rom_ok) begin
          fill_s   = 1'b1;
          ptr_d    = ptr_nx_s;
          rom_cs_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (cnt_q == TMO_W'(TMO - 1)) begin
          // Abandon the fetch without touching the cache; move on to the next client.
          ptr_d    = ptr_nx_s;
          rom_cs_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        rom_cs_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Cache fill: the latched fetch address becomes the tag, so a client that moved on still misses.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      tag_d[i]  = tag_q[i];
      data_d[i] = data_q[i];
    end
    vld_d = vld_q;
    if (fill_s) begin
      tag_d[sel_q]  = addr_l_q;
      data_d[sel_q] = rom.rom_data;
      vld_d[sel_q]  = 1'b1;
    end else begin
      vld_d = vld_q;
    end
  end

  // State, fetch and cache registers; reset drops any fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= {PW{1'b0}};
      sel_q    <= {PW{1'b0}};
      addr_l_q <= {AW{1'b0}};
      cnt_q    <= {TMO_W{1'b0}};
      rom_cs_q <= 1'b0;
      vld_q    <= {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        tag_q[i]  <= {AW{1'b0}};
        data_q[i] <= {DW{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      addr_l_q <= addr_l_d;
      cnt_q    <= cnt_d;
      rom_cs_q <= rom_cs_d;
      vld_q    <= vld_d;
      for (int i = 0; i < N; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule
